// File: rtl/risc_pkg.sv
// Shared definitions for the multi-cycle RISC core: opcodes, one-hot state encoding,
// and instruction field positions.
package risc_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SHL  = 4'h5;
    localparam logic [3:0] OP_SHR  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_LI   = 4'h8;
    localparam logic [3:0] OP_MOV  = 4'h9;
    localparam logic [3:0] OP_DISP = 4'hA;
    localparam logic [3:0] OP_BEQZ = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_NOP  = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hE;
    localparam logic [3:0] OP_ILL  = 4'hF;

    localparam int ST_FETCH     = 0;
    localparam int ST_DECODE    = 1;
    localparam int ST_EXECUTE   = 2;
    localparam int ST_WRITEBACK = 3;
    localparam int ST_HALT      = 4;
    localparam int ST_COUNT     = 5;

    typedef enum logic [ST_COUNT-1:0] {
        S_FETCH     = ST_COUNT'(1 << ST_FETCH),
        S_DECODE    = ST_COUNT'(1 << ST_DECODE),
        S_EXECUTE   = ST_COUNT'(1 << ST_EXECUTE),
        S_WRITEBACK = ST_COUNT'(1 << ST_WRITEBACK),
        S_HALT      = ST_COUNT'(1 << ST_HALT)
    } state_t;

    localparam int F_OP_LSB  = 12;
    localparam int F_RA_LSB  = 8;
    localparam int F_RB_LSB  = 4;
    localparam int F_IMM_LSB = 0;

    // Opcodes ADD..MOV are the only ones that write the destination register.
    function automatic logic writes_reg(input logic [3:0] op);
        return op <= OP_MOV;
    endfunction

endpackage

// File: rtl/risc_alu.sv
// Combinational ALU; operand b already carries the sign-extended immediate for ADDI/LI.
module risc_alu
    import risc_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD, OP_ADDI: result = a + b;
            OP_SUB:          result = a - b;
            OP_AND:          result = a & b;
            OP_OR:           result = a | b;
            OP_XOR:          result = a ^ b;
            OP_SHL:          result = a << b[3:0];
            OP_SHR:          result = a >> b[3:0];
            OP_LI, OP_MOV:   result = b;
            default:         result = '0;
        endcase
    end

endmodule

// File: rtl/risc_core_p.sv
// Parametrised multi-cycle 16-bit-instruction RISC core: FETCH/DECODE/EXECUTE/WRITEBACK/HALT
// sequencing with register file, PC and display register.
module risc_core_p
    import risc_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int REG_COUNT = 16,
    parameter int PC_W      = 8,
    parameter int DISP_INV  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              instr_valid,
    input  logic [15:0]       instruction,
    output logic              instr_req,
    output logic [PC_W-1:0]   pc_out,
    output logic [4:0]        tick_out,
    output logic [DATA_W-1:0] display,
    output logic              illegal
);

    state_t            state_reg, state_next;
    logic [15:0]       ir_reg;
    logic [DATA_W-1:0] a_reg, b_reg, result_reg;
    logic              taken_reg;
    logic [PC_W-1:0]   pc_reg;
    logic [DATA_W-1:0] display_reg;
    logic [DATA_W-1:0] rf_reg [REG_COUNT];

    logic [3:0]        ir_op, ra_idx, rb_idx;
    logic [7:0]        imm8;
    logic [DATA_W-1:0] imm_data, ra_val, rb_val, alu_result;
    logic [PC_W-1:0]   imm_pc;
    logic              wb_write;
    logic [REG_COUNT-1:0] rf_we;

    assign ir_op    = ir_reg[F_OP_LSB +: 4];
    assign ra_idx   = ir_reg[F_RA_LSB +: 4];
    assign rb_idx   = ir_reg[F_RB_LSB +: 4];
    assign imm8     = ir_reg[F_IMM_LSB +: 8];
    assign imm_data = DATA_W'($signed(imm8));
    assign imm_pc   = PC_W'($signed(imm8));

    // Indices beyond REG_COUNT match no entry, so they read 0 and never write.
    always_comb begin
        ra_val = '0;
        rb_val = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (ra_idx == 4'(i)) ra_val = rf_reg[i];
            if (rb_idx == 4'(i)) rb_val = rf_reg[i];
        end
    end

    assign wb_write = enable && (state_reg == S_WRITEBACK) && writes_reg(ir_op);

    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_rf_we
        assign rf_we[gi] = wb_write && (ra_idx == 4'(gi));
    end

    risc_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (a_reg),
        .b      (b_reg),
        .op     (ir_op),
        .result (alu_result)
    );

    always_comb begin
        state_next = state_reg;
        if (enable) begin
            case (state_reg)
                S_FETCH:     if (instr_valid) state_next = S_DECODE;
                S_DECODE:    state_next = S_EXECUTE;
                S_EXECUTE:   state_next = S_WRITEBACK;
                S_WRITEBACK: state_next = (ir_op == OP_HALT) ? S_HALT : S_FETCH;
                S_HALT:      state_next = S_HALT;
                default:     state_next = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_FETCH;
            ir_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            result_reg  <= '0;
            taken_reg   <= 1'b0;
            pc_reg      <= '0;
            display_reg <= (DISP_INV != 0) ? '1 : '0;
            for (int i = 0; i < REG_COUNT; i++) rf_reg[i] <= '0;
        end else if (enable) begin
            state_reg <= state_next;
            for (int i = 0; i < REG_COUNT; i++) begin
                if (rf_we[i]) rf_reg[i] <= result_reg;
            end
            case (state_reg)
                S_FETCH: if (instr_valid) ir_reg <= instruction;
                S_DECODE: begin
                    a_reg <= ra_val;
                    b_reg <= (ir_op == OP_ADDI || ir_op == OP_LI) ? imm_data : rb_val;
                end
                S_EXECUTE: begin
                    result_reg <= alu_result;
                    taken_reg  <= (ir_op == OP_JMP) || (ir_op == OP_BEQZ && a_reg == '0);
                end
                S_WRITEBACK: begin
                    if (ir_op == OP_DISP) display_reg <= (DISP_INV != 0) ? ~a_reg : a_reg;
                    pc_reg <= taken_reg ? pc_reg + imm_pc : pc_reg + PC_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign instr_req = (state_reg == S_FETCH);
    assign tick_out  = state_reg;
    assign pc_out    = pc_reg;
    assign display   = display_reg;
    assign illegal   = (state_reg == S_WRITEBACK) && (ir_op == OP_ILL);

endmodule

// File: tb/tb_risc_core_p.sv
// Scenario bench for risc_core_p: a reference model pushes expected PC/display per
// instruction and the values are popped and compared when the instruction retires.
module tb_risc_core_p;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instruction = 16'h0;

    logic        instr_req, illegal;
    logic [7:0]  pc_out;
    logic [4:0]  tick_out;
    logic [15:0] display;

    logic        instr_req4, illegal4;
    logic [7:0]  pc_out4;
    logic [4:0]  tick_out4;
    logic [15:0] display4;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_rf [16];
    logic [7:0]  m_pc;
    logic [15:0] m_disp;
    logic [7:0]  exp_pc_q [$];
    logic [15:0] exp_disp_q [$];

    always #5 clk = ~clk;

    risc_core_p u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .instr_valid(instr_valid),
        .instruction(instruction), .instr_req(instr_req), .pc_out(pc_out),
        .tick_out(tick_out), .display(display), .illegal(illegal)
    );

    risc_core_p #(.REG_COUNT(4), .DISP_INV(0)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .instr_valid(instr_valid),
        .instruction(instruction), .instr_req(instr_req4), .pc_out(pc_out4),
        .tick_out(tick_out4), .display(display4), .illegal(illegal4)
    );

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_rf[i] = 16'h0;
        m_pc   = 8'h00;
        m_disp = 16'hFFFF;
        exp_pc_q.delete();
        exp_disp_q.delete();
    endtask

    task automatic model_step(input logic [15:0] ins);
        logic [3:0]  op, ra, rb;
        logic [7:0]  imm;
        logic [15:0] sd, a, b, res;
        op = ins[15:12]; ra = ins[11:8]; rb = ins[7:4]; imm = ins[7:0];
        sd = {{8{imm[7]}}, imm};
        a = m_rf[ra]; b = m_rf[rb];
        res = 16'h0;
        case (op)
            4'h0: res = a + b;
            4'h1: res = a - b;
            4'h2: res = a & b;
            4'h3: res = a | b;
            4'h4: res = a ^ b;
            4'h5: res = a << b[3:0];
            4'h6: res = a >> b[3:0];
            4'h7: res = a + sd;
            4'h8: res = sd;
            4'h9: res = b;
            default: res = 16'h0;
        endcase
        if (op <= 4'h9) m_rf[ra] = res;
        if (op == 4'hA) m_disp = ~a;
        if (op == 4'hC || (op == 4'hB && a == 16'h0)) m_pc = m_pc + imm;
        else m_pc = m_pc + 8'h01;
        exp_pc_q.push_back(m_pc);
        exp_disp_q.push_back(m_disp);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b1;
        model_reset();
    endtask

    // Runs one instruction to retirement; optional FETCH stall and EXECUTE freeze cycles.
    task automatic run_instr(input logic [15:0] ins, input int stall, input int freeze,
                             output int cycles, output int ill_cnt);
        int guard;
        logic [7:0]  epc;
        logic [15:0] edisp;
        guard = 0;
        while (tick_out !== 5'b00001 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (tick_out !== 5'b00001) begin
            errors++;
            $display("FAIL fetch_ready ins=%h tick_out=%b required 00001", ins, tick_out);
        end
        model_step(ins);
        instruction = ins;
        cycles = 0;
        ill_cnt = 0;
        for (int s = 0; s < stall; s++) begin
            instr_valid = 1'b0;
            @(negedge clk);
            cycles++;
            checks++;
            if (tick_out !== 5'b00001 || instr_req !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold tick_out=%b instr_req=%b required 00001/1", tick_out, instr_req);
            end
        end
        instr_valid = 1'b1;
        @(negedge clk);
        cycles++;
        instr_valid = 1'b0;
        ill_cnt += int'(illegal);
        checks++;
        if (tick_out !== 5'b00010) begin
            errors++;
            $display("FAIL decode_state ins=%h tick_out=%b required 00010", ins, tick_out);
        end
        @(negedge clk);
        cycles++;
        ill_cnt += int'(illegal);
        for (int f = 0; f < freeze; f++) begin
            enable = 1'b0;
            @(negedge clk);
            cycles++;
            ill_cnt += int'(illegal);
            checks++;
            if (tick_out !== 5'b00100) begin
                errors++;
                $display("FAIL freeze_state tick_out=%b required 00100", tick_out);
            end
        end
        enable = 1'b1;
        @(negedge clk);
        cycles++;
        ill_cnt += int'(illegal);
        @(negedge clk);
        cycles++;
        ill_cnt += int'(illegal);
        checks++;
        if (exp_pc_q.size() == 0 || exp_disp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty ins=%h", ins);
        end else begin
            epc = exp_pc_q.pop_front();
            edisp = exp_disp_q.pop_front();
            checks++;
            if (pc_out !== epc || display !== edisp) begin
                errors++;
                $display("FAIL retire ins=%h pc=%h display=%h required pc=%h display=%h",
                         ins, pc_out, display, epc, edisp);
            end
        end
        $display("instr %h: pc=%h display=%h cycles=%0d", ins, pc_out, display, cycles);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (tick_out !== 5'b00001 || pc_out !== 8'h00 || display !== 16'hFFFF ||
            illegal !== 1'b0 || instr_req !== 1'b1) begin
            errors++;
            $display("FAIL %s tick=%b pc=%h disp=%h ill=%b req=%b required 00001/00/FFFF/0/1",
                     tag, tick_out, pc_out, display, illegal, instr_req);
        end
        checks++;
        if (tick_out4 !== 5'b00001 || pc_out4 !== 8'h00 || display4 !== 16'h0000 || illegal4 !== 1'b0) begin
            errors++;
            $display("FAIL %s_small tick=%b pc=%h disp=%h ill=%b required 00001/00/0000/0",
                     tag, tick_out4, pc_out4, display4, illegal4);
        end
    endtask

    task automatic test_reset();
        enable = 1'b0;
        rst_n = 1'b0;
        instr_valid = 1'b1;
        instruction = 16'h8155;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        instr_valid = 1'b0;
        enable = 1'b1;
        model_reset();
        $display("reset: tick=%b pc=%h display=%h", tick_out, pc_out, display);
    endtask

    task automatic test_basic();
        int cyc, ill, total;
        logic [15:0] prog [4];
        prog[0] = 16'h8105; prog[1] = 16'h82FD; prog[2] = 16'h0120; prog[3] = 16'hA100;
        total = 0;
        for (int i = 0; i < 4; i++) begin
            run_instr(prog[i], 0, 0, cyc, ill);
            total += cyc;
        end
        checks++;
        if (total !== 16 || display !== 16'hFFFD || pc_out !== 8'h04) begin
            errors++;
            $display("FAIL basic_program cycles=%0d display=%h pc=%h required 16/FFFD/04", total, display, pc_out);
        end
    endtask

    task automatic test_stall();
        int cyc_base, cyc_stall, ill;
        run_instr(16'hD000, 0, 0, cyc_base, ill);
        run_instr(16'hD000, 3, 0, cyc_stall, ill);
        checks++;
        if (cyc_base !== 4 || cyc_stall !== 7) begin
            errors++;
            $display("FAIL stall_latency base=%0d stalled=%0d required 4/7", cyc_base, cyc_stall);
        end
    endtask

    task automatic test_branch();
        int cyc, ill;
        apply_reset();
        run_instr(16'h8300, 0, 0, cyc, ill);
        run_instr(16'hD000, 0, 0, cyc, ill);
        run_instr(16'hB3FC, 0, 0, cyc, ill);
        checks++;
        if (pc_out !== 8'hFE) begin
            errors++;
            $display("FAIL beqz_taken pc=%h required FE", pc_out);
        end
        run_instr(16'hC005, 0, 0, cyc, ill);
        apply_reset();
        run_instr(16'h8301, 0, 0, cyc, ill);
        run_instr(16'hD000, 0, 0, cyc, ill);
        run_instr(16'hB3FC, 0, 0, cyc, ill);
        checks++;
        if (pc_out !== 8'h03) begin
            errors++;
            $display("FAIL beqz_not_taken pc=%h required 03", pc_out);
        end
    endtask

    task automatic test_enable_freeze();
        int cyc, ill;
        apply_reset();
        run_instr(16'h747F, 0, 2, cyc, ill);
        run_instr(16'hA400, 0, 0, cyc, ill);
        checks++;
        if (display !== 16'hFF80) begin
            errors++;
            $display("FAIL freeze_single_write display=%h required FF80", display);
        end
    endtask

    task automatic test_illegal_halt();
        int cyc, ill;
        logic [7:0] held_pc;
        run_instr(16'hF000, 0, 0, cyc, ill);
        checks++;
        if (ill !== 1) begin
            errors++;
            $display("FAIL illegal_pulse cycles_high=%0d required 1", ill);
        end
        run_instr(16'hE000, 0, 0, cyc, ill);
        held_pc = m_pc;
        instr_valid = 1'b1;
        instruction = 16'h8177;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (tick_out !== 5'b10000 || pc_out !== held_pc || instr_req !== 1'b0) begin
                errors++;
                $display("FAIL halt_hold cycle=%0d tick=%b pc=%h req=%b required 10000/%h/0",
                         i, tick_out, pc_out, instr_req, held_pc);
            end
        end
        instr_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (tick_out !== 5'b00001 || pc_out !== 8'h00) begin
            errors++;
            $display("FAIL halt_exit tick=%b pc=%h required 00001/00", tick_out, pc_out);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_small_regfile();
        int cyc, ill;
        run_instr(16'h8033, 0, 0, cyc, ill);
        run_instr(16'hA000, 0, 0, cyc, ill);
        checks++;
        if (display4 !== 16'h0033) begin
            errors++;
            $display("FAIL small_disp_r0 display=%h required 0033", display4);
        end
        run_instr(16'h8911, 0, 0, cyc, ill);
        run_instr(16'hA900, 0, 0, cyc, ill);
        checks++;
        if (display4 !== 16'h0000) begin
            errors++;
            $display("FAIL small_read_r9 display=%h required 0000", display4);
        end
        run_instr(16'h9090, 0, 0, cyc, ill);
        run_instr(16'hA000, 0, 0, cyc, ill);
        checks++;
        if (display4 !== 16'h0000 || display !== 16'hFFEE) begin
            errors++;
            $display("FAIL small_mov_r0 display4=%h display=%h required 0000/FFEE", display4, display);
        end
    endtask

    task automatic test_reset_mid_decode();
        instruction = 16'h8507;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        checks++;
        if (tick_out !== 5'b00010) begin
            errors++;
            $display("FAIL mid_decode_entry tick=%b required 00010", tick_out);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_mid_decode");
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_back_to_back();
        int cyc, ill;
        logic [15:0] ins;
        for (int r = 1; r < 8; r++) begin
            ins = {4'h8, 4'(r), 8'($urandom_range(0, 255))};
            run_instr(ins, 0, 0, cyc, ill);
        end
        for (int i = 0; i < 14; i++) begin
            ins = {4'($urandom_range(0, 9)), 4'($urandom_range(1, 7)),
                   4'($urandom_range(1, 7)), 4'($urandom_range(0, 15))};
            run_instr(ins, $urandom_range(0, 1), 0, cyc, ill);
            run_instr({4'hA, ins[11:8], 8'h00}, 0, 0, cyc, ill);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_branch();
        test_enable_freeze();
        test_illegal_halt();
        test_small_regfile();
        test_reset_mid_decode();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
